// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller: FSM state encodings and timeout default.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH2   = 2'd2,
    ST_LU_STALL = 2'd3
  } state_e;

  localparam int unsigned MEM_TIMEOUT_DEF = 15;
  localparam int unsigned WAIT_CNT_W      = 8;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detector: flags a decode read of the register an in-flight load will write.
module hazard_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [1:0] id_rs_use,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  input  logic       ex_rb_wr,
  output logic       lu_haz
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_rs_use[0] && (id_rs1 == ex_rd);
  assign rs2_hit = id_rs_use[1] && (id_rs2 == ex_rd);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lu_haz  = ex_is_load && ex_rb_wr && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, branch flushes, data-memory wait with timeout.
// Optional PIPE_CTRL_PERF_EN adds saturating stall and flush event counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [1:0] id_rs_use,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  input  logic       ex_rb_wr,
  input  logic       br_taken,
  input  logic       dm_req,
  input  logic       dm_ack,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       mem_err,
  output logic [1:0] state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  localparam logic [WAIT_CNT_W-1:0] TO_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  lu_haz;

  hazard_detect u_hazard_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rs_use  (id_rs_use),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .ex_rb_wr   (ex_rb_wr),
    .lu_haz     (lu_haz)
  );

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    mem_err     = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      ST_RUN: begin
        if (dm_req && !dm_ack) begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          id_ex_en = 1'b0;
          cnt_d    = '0;
          state_d  = ST_MEM_WAIT;
        end else if (br_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = ST_FLUSH2;
        end else if (lu_haz) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          state_d     = ST_LU_STALL;
        end
      end
      ST_MEM_WAIT: begin
        if (dm_ack) begin
          if (br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = ST_FLUSH2;
          end else begin
            state_d = ST_RUN;
          end
        end else if (cnt_q == TO_LAST) begin
          // Abort: release the pipe and squash the stuck memory instruction.
          mem_err     = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = ST_RUN;
        end else begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          id_ex_en = 1'b0;
          cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
      end
      // The synchronous IMEM still delivers one fetch from the wrong path.
      ST_FLUSH2: begin
        if_id_flush = 1'b1;
        state_d     = ST_RUN;
      end
      ST_LU_STALL: begin
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    if (rst) begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      mem_err     = 1'b0;
      state_d     = ST_RUN;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Both flushes together only occur when a branch redirect is accepted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    if (if_id_flush && id_ex_flush && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl; expected output word is
// {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, mem_err, state[1:0]}.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic [1:0] id_rs_use;
  logic       ex_is_load, ex_rb_wr, br_taken, dm_req, dm_ack;
  logic       pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, mem_err;
  logic [1:0] state;

  int vectors = 0;
  int errors  = 0;

  localparam logic [7:0] RUN_IDLE  = 8'b111_0_0_0_00;
  localparam logic [7:0] MW_STALL  = 8'b000_0_0_0_01;
  localparam logic [7:0] FLUSH2_O  = 8'b111_1_0_0_10;
  localparam logic [7:0] BR_RUN    = 8'b111_1_1_0_00;
  localparam logic [7:0] LU_RUN    = 8'b001_0_1_0_00;
  localparam logic [7:0] RUN_STALL = 8'b000_0_0_0_00;

  pipe_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs_use   (id_rs_use),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .ex_rb_wr    (ex_rb_wr),
    .br_taken    (br_taken),
    .dm_req      (dm_req),
    .dm_ack      (dm_ack),
    .pc_en       (pc_en),
    .if_id_en    (if_id_en),
    .id_ex_en    (id_ex_en),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .mem_err     (mem_err),
    .state       (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, mem_err, state};
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clear_ins();
    id_rs1 = '0; id_rs2 = '0; id_rs_use = '0; ex_rd = '0;
    ex_is_load = 0; ex_rb_wr = 0; br_taken = 0; dm_req = 0; dm_ack = 0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [1:0] use_v);
    ex_is_load = 1; ex_rb_wr = 1; ex_rd = rd;
    id_rs1 = rs1; id_rs2 = rs2; id_rs_use = use_v;
  endtask

  initial begin
    clear_ins();
    rst = 1;
    @(posedge clk);
    @(negedge clk); #1 chk("reset", 8'b111_1_1_0_00);
    @(negedge clk); rst = 0; #1 chk("run_idle", RUN_IDLE);

    // Load-use hazard on rs1, one bubble, held inputs ignored in LU_STALL
    @(negedge clk); set_load(5'd5, 5'd5, 5'd0, 2'b01); #1 chk("lu_rs1", LU_RUN);
    @(negedge clk); #1 chk("lu_stall", 8'b111_0_0_0_11);
    @(negedge clk); clear_ins(); #1 chk("lu_back_run", RUN_IDLE);
    @(negedge clk); set_load(5'd0, 5'd0, 5'd0, 2'b01); #1 chk("lu_rd0", RUN_IDLE);
    @(negedge clk); set_load(5'd7, 5'd1, 5'd7, 2'b10); #1 chk("lu_rs2", LU_RUN);
    @(negedge clk); clear_ins(); #1 chk("lu_stall2", 8'b111_0_0_0_11);
    @(negedge clk); set_load(5'd9, 5'd9, 5'd9, 2'b00); #1 chk("lu_nouse", RUN_IDLE);
    @(negedge clk); set_load(5'd9, 5'd9, 5'd9, 2'b01); ex_rb_wr = 0; #1 chk("lu_nowr", RUN_IDLE);
    @(negedge clk); clear_ins();

    // Branch: two-cycle if_id flush, single id_ex flush
    br_taken = 1; #1 chk("br_first", BR_RUN);
    @(negedge clk); br_taken = 0; #1 chk("br_second", FLUSH2_O);
    @(negedge clk); #1 chk("br_done", RUN_IDLE);

    // Branch beats load-use; FLUSH2 ignores the hazard still present
    @(negedge clk); set_load(5'd3, 5'd3, 5'd0, 2'b01); br_taken = 1; #1 chk("br_over_lu", BR_RUN);
    @(negedge clk); br_taken = 0; #1 chk("f2_ign_lu", FLUSH2_O);
    @(negedge clk); clear_ins(); #1 chk("f2_done", RUN_IDLE);

    // Memory wait, ack on the 4th cycle: three stalled cycles
    @(negedge clk); dm_req = 1; #1 chk("mw_req", RUN_STALL);
    @(negedge clk); #1 chk("mw_1", MW_STALL);
    @(negedge clk); #1 chk("mw_2", MW_STALL);
    @(negedge clk); dm_ack = 1; #1 chk("mw_ack", 8'b111_0_0_0_01);
    @(negedge clk); dm_req = 0; dm_ack = 0; #1 chk("mw_done", RUN_IDLE);

    // Same-cycle ack: no stall, branch still honoured; FLUSH2 defers a new request
    @(negedge clk); dm_req = 1; dm_ack = 1; #1 chk("req_ack_same", RUN_IDLE);
    @(negedge clk); br_taken = 1; #1 chk("req_ack_br", BR_RUN);
    @(negedge clk); br_taken = 0; dm_ack = 0; #1 chk("f2_req", FLUSH2_O);
    @(negedge clk); #1 chk("req_after_f2", RUN_STALL);
    @(negedge clk); dm_ack = 1; br_taken = 1; #1 chk("mw_ack_br", 8'b111_1_1_0_01);
    @(negedge clk); clear_ins(); #1 chk("mw_ack_br_f2", FLUSH2_O);
    @(negedge clk); #1 chk("mw_ack_br_run", RUN_IDLE);

    // Timeout: mem_err on the 15th wait cycle
    @(negedge clk); dm_req = 1; #1 chk("to_req", RUN_STALL);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk); #1 chk($sformatf("to_wait%0d", i + 1), MW_STALL);
    end
    @(negedge clk); #1 chk("to_err", 8'b111_0_1_1_01);
    @(negedge clk); dm_req = 0; #1 chk("to_run", RUN_IDLE);

    // Reset during MEM_WAIT abandons without mem_err
    @(negedge clk); dm_req = 1; #1 chk("rmw_req", RUN_STALL);
    @(negedge clk); #1 chk("rmw_wait", MW_STALL);
    @(negedge clk); rst = 1; #1 chk("rmw_rst", 8'b111_1_1_0_01);
    @(negedge clk); rst = 0; dm_req = 0; #1 chk("rmw_after", RUN_IDLE);

    // Reset during FLUSH2
    @(negedge clk); br_taken = 1; #1 chk("rf2_br", BR_RUN);
    @(negedge clk); br_taken = 0; rst = 1; #1 chk("rf2_rst", 8'b111_1_1_0_10);
    @(negedge clk); rst = 0; #1 chk("rf2_after", RUN_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
